myproject_mul_share_arb: RTL and testbench
==========================================

MYPROJECT_MUL_SHARE_ARB -- requirements
Module: myproject_mul_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing one multiplier (legal range 2..8).
REQ-002 SHALL have parameter NUM_STAGE, default 2, meaning the multiply pipeline depth in cycles (legal range 1..4).
REQ-003 SHALL have parameters din0_WIDTH = 16, din1_WIDTH = 7 and dout_WIDTH = 23, meaning the signed operand and product widths.
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: global advance enable; low freezes grants and pipeline.
REQ-007 SHALL have port req_valid, input, N_REQ bits: per-requester operand valid.
REQ-008 SHALL have port req_ready, output, N_REQ bits: per-requester grant/accept, one-hot or zero.
REQ-009 SHALL have port req_a, input, N_REQ*16 bits: packed signed din0 operands; slice i belongs to requester i.
REQ-010 SHALL have port req_b, input, N_REQ*7 bits: packed signed din1 operands; slice i belongs to requester i.
REQ-011 SHALL have port rsp_valid, output, N_REQ bits: one-hot single-cycle result strobe naming the owner.
REQ-012 SHALL have port rsp_dout, output, 23 bits: signed product for the strobed requester.
REQ-013 SHALL have port inflight, output, 3 bits: the count of accepted operations not yet returned.

Function
REQ-014 SHALL accept at most one operation per cycle, and only when en=1.
REQ-015 SHALL grant by round robin: priority starts at the index after the last accepted requester, wraps N_REQ-1 to 0, and starts at requester 0 after reset.
REQ-016 SHALL drive req_ready combinationally from req_valid, the pointer and en; req_ready[i]=1 only when req_valid[i]=1.
REQ-017 SHALL treat a transfer as req_valid[i] & req_ready[i] at a rising edge; the pointer advances only on a transfer.
REQ-018 SHALL leave the pointer unchanged when no requester is valid.
REQ-019 SHALL compute the full-precision signed product, a*b, with no rounding, saturation or truncation; -32768*-64 = +2097152 fits in 23 bits.
REQ-020 SHALL carry a valid bit and the owner index alongside the operands through every pipeline stage.
REQ-021 SHALL have fixed latency: an operation accepted at edge k asserts rsp_valid in the cycle after edge k+NUM_STAGE-1, counting only edges with en=1.
REQ-022 SHALL, when en=0, hold all pipeline registers, rsp_valid, rsp_dout and the pointer, and assert no req_ready.
REQ-023 SHALL drive rsp_dout to 0 in any cycle where rsp_valid is all zero.
REQ-024 SHALL provide no response backpressure; each requester must take its result on the strobe cycle.
REQ-025 SHALL increment inflight on accept, decrement it on return, and leave it unchanged when both occur on the same edge.
REQ-026 SHALL sustain back-to-back acceptance, one per cycle, with no bubbles while requests are pending and en=1.

Reset
REQ-027 SHALL, on ap_rst_n low at any time, asynchronously clear all pipeline valid bits, the pointer (to 0), inflight, rsp_valid and rsp_dout.
REQ-028 SHALL discard operations in flight at reset; they are never returned.
REQ-029 SHALL hold req_ready at 0 while ap_rst_n is low.
REQ-030 SHALL resume normal operation on the first rising edge after ap_rst_n is deasserted.

Structure
REQ-031 SHALL place the widths 16/7/23, a max-N_REQ constant and the index-width function in a shared package, myproject_mul_share_pkg.
REQ-032 SHALL instantiate exactly one sub-module, myproject_mul_share_dsp: a NUM_STAGE-registered signed 16x7->23 multiplier with clock enable, mapping to one DSP48.
REQ-033 SHALL implement the arbiter, tag/valid pipeline and inflight counter in the top module.

Verification
REQ-034 SHALL verify single request: req 2 with a=100, b=-3, en=1 -> rsp_valid=0100 and rsp_dout=-300 exactly NUM_STAGE cycles later, with inflight returning to 0.
REQ-035 SHALL verify fairness: all four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and 8 strobes in the same order.
REQ-036 SHALL verify extremes: (-32768,-64) -> +2097152; (32767,63) -> 2064321; (-32768,63) -> -2064384.
REQ-037 SHALL verify stall: en=0 for 3 cycles mid-stream -> no req_ready, outputs frozen, results later return with latency extended by 3 and no loss or duplication.
REQ-038 SHALL verify reset mid-operation: with 2 operations in flight, ap_rst_n pulses low between edges -> outputs clear immediately, no stale strobe appears, and the pointer restarts at 0.
REQ-039 SHALL verify simultaneous accept and return: continuous single-requester traffic -> inflight stays constant at NUM_STAGE.

Source files
------------

// File: rtl/myproject_mul_share_pkg.sv
// Shared widths and helpers for the shared-multiplier arbiter.
// The operands are signed 16 and 7 bits wide. The full-precision product is 23 bits wide.
package myproject_mul_share_pkg;

    localparam int DIN0_W    = 16;
    localparam int DIN1_W    = 7;
    localparam int DOUT_W    = 23;
    localparam int MAX_N_REQ = 8;

    // Number of bits needed to index n items. The result is never less than 1.
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/myproject_mul_share_dsp.sv
// Signed 16x7 -> 23 multiplier with NUM_STAGE clock-enabled product registers.
// The registers carry no reset, so the multiplier can be packed into a single DSP slice.
module myproject_mul_share_dsp
    import myproject_mul_share_pkg::*;
#(
    parameter int NUM_STAGE = 2
) (
    input  logic                     clk_i,
    input  logic                     ce_i,
    input  logic signed [DIN0_W-1:0] a_i,
    input  logic signed [DIN1_W-1:0] b_i,
    output logic signed [DOUT_W-1:0] p_o
);

    logic signed [DOUT_W-1:0] prod;
    logic signed [DOUT_W-1:0] p_q [NUM_STAGE];

    // Both operands are sign-extended to the product width, so the product is exact.
    assign prod = DOUT_W'(a_i) * DOUT_W'(b_i);

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            p_q[0] <= prod;
            for (int s = 1; s < NUM_STAGE; s++) begin
                p_q[s] <= p_q[s-1];
            end
        end
    end

    assign p_o = p_q[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mul_share_arb.sv
// N_REQ requesters share one pipelined multiplier through a round-robin arbiter.
// The owner index and valid bit travel alongside the product, and the result comes back as a one-hot strobe.
module myproject_mul_share_arb
    import myproject_mul_share_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          en,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*din0_WIDTH-1:0]   req_a,
    input  logic [N_REQ*din1_WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic signed [dout_WIDTH-1:0]  rsp_dout,
    output logic [2:0]                    inflight
);

    localparam int IW   = idx_w(N_REQ);
    localparam int LAST = NUM_STAGE - 1;

    logic [IW-1:0]                ptr_q, ptr_d;
    logic [IW-1:0]                gnt_idx;
    logic                         found;
    logic                         accept;
    logic                         ret;
    int                           rr_idx;
    logic [NUM_STAGE-1:0]         vld_q;
    logic [IW-1:0]                own_q [NUM_STAGE];
    logic [2:0]                   inflight_q, inflight_d;
    logic signed [din0_WIDTH-1:0] a_sel;
    logic signed [din1_WIDTH-1:0] b_sel;
    logic signed [dout_WIDTH-1:0] dsp_p;

    // Round-robin search starts at ptr_q and wraps. The first valid requester found wins the grant.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        rr_idx  = 0;
        for (int off = 0; off < N_REQ; off++) begin
            rr_idx = int'(ptr_q) + off;
            if (rr_idx >= N_REQ) begin
                rr_idx = rr_idx - N_REQ;
            end
            if (!found && req_valid[rr_idx]) begin
                found   = 1'b1;
                gnt_idx = IW'(rr_idx);
            end
        end
    end

    assign accept    = found & en & ap_rst_n;
    assign req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;
    assign ptr_d     = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    assign ret       = vld_q[LAST] & en;

    assign a_sel = req_a[int'(gnt_idx)*din0_WIDTH +: din0_WIDTH];
    assign b_sel = req_b[int'(gnt_idx)*din1_WIDTH +: din1_WIDTH];

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, ret})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q      <= '0;
            vld_q      <= '0;
            inflight_q <= '0;
        end else if (en) begin
            vld_q[0] <= accept;
            for (int s = 1; s < NUM_STAGE; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
            if (accept) begin
                ptr_q <= ptr_d;
            end
            inflight_q <= inflight_d;
        end
    end

    // The owner tags are data. They have no reset because they are only meaningful when vld_q is set.
    always_ff @(posedge ap_clk) begin
        if (en) begin
            own_q[0] <= gnt_idx;
            for (int s = 1; s < NUM_STAGE; s++) begin
                own_q[s] <= own_q[s-1];
            end
        end
    end

    myproject_mul_share_dsp #(
        .NUM_STAGE(NUM_STAGE)
    ) u_dsp (
        .clk_i (ap_clk),
        .ce_i  (en),
        .a_i   (a_sel),
        .b_i   (b_sel),
        .p_o   (dsp_p)
    );

    assign rsp_valid = vld_q[LAST] ? (N_REQ'(1) << own_q[LAST]) : '0;
    assign rsp_dout  = vld_q[LAST] ? dsp_p : '0;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Directed bench for the shared-multiplier arbiter, using the default configuration N_REQ=4, NUM_STAGE=2.
// It covers table-driven single products, then fairness, stall, mid-flight reset and steady-state occupancy.
module tb_myproject_mul_share_arb;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               en = 1'b0;
    logic [3:0]         req_valid = '0;
    logic [3:0]         req_ready;
    logic [63:0]        req_a = '0;
    logic [27:0]        req_b = '0;
    logic [3:0]         rsp_valid;
    logic signed [22:0] rsp_dout;
    logic [2:0]         inflight;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int idx;
        int a;
        int b;
        int p;
    } vec_t;

    vec_t vecs[7];
    int   fa[4];
    int   fb[4];
    int   fp[4];
    int   n_str;

    myproject_mul_share_arb #(
        .N_REQ(4),
        .NUM_STAGE(2)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout),
        .inflight  (inflight)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        step();
        ap_rst_n = 1'b1;
    endtask

    task automatic load_fair_ops();
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(fa[i]);
            req_b[i*7 +: 7]   = 7'(fb[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{idx: 2, a: 100,    b: -3,  p: -300};
        vecs[1] = '{idx: 0, a: -32768, b: -64, p: 2097152};
        vecs[2] = '{idx: 1, a: 32767,  b: 63,  p: 2064321};
        vecs[3] = '{idx: 3, a: -32768, b: 63,  p: -2064384};
        vecs[4] = '{idx: 0, a: 0,      b: 5,   p: 0};
        vecs[5] = '{idx: 1, a: -1,     b: -1,  p: 1};
        vecs[6] = '{idx: 3, a: 1234,   b: -64, p: -78976};
        fa = '{1000, 2000, 3000, 4000};
        fb = '{-1, 2, -3, 4};
        fp = '{-1000, 4000, -9000, 16000};

        // Reset state: the inputs are active but reset holds every output clear.
        req_valid = 4'hF;
        en = 1'b1;
        #12;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_dout", int'(rsp_dout), 0);
        chk("rst_inflight", int'(inflight), 0);
        req_valid = '0;
        step();
        ap_rst_n = 1'b1;

        // Single-operation vectors from the table.
        for (int v = 0; v < 7; v++) begin
            req_a[vecs[v].idx*16 +: 16] = 16'(vecs[v].a);
            req_b[vecs[v].idx*7 +: 7]   = 7'(vecs[v].b);
            req_valid = 4'(1 << vecs[v].idx);
            #1;
            chk("vec_ready", int'(req_ready), 1 << vecs[v].idx);
            step();
            req_valid = '0;
            chk("vec_early_rsp", int'(rsp_valid), 0);
            chk("vec_inflight_acc", int'(inflight), 1);
            step();
            chk("vec_rsp_valid", int'(rsp_valid), 1 << vecs[v].idx);
            chk("vec_rsp_dout", int'(rsp_dout), vecs[v].p);
            chk("vec_inflight_rsp", int'(inflight), 1);
            step();
            chk("vec_rsp_clear", int'(rsp_valid), 0);
            chk("vec_dout_zero", int'(rsp_dout), 0);
            chk("vec_inflight_end", int'(inflight), 0);
        end

        // Fairness: all four requesters stay valid for 8 cycles.
        do_reset();
        load_fair_ops();
        req_valid = 4'hF;
        n_str = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            if (c < 8) chk("fair_grant", int'(req_ready), 1 << (c % 4));
            step();
            if (rsp_valid != '0) begin
                chk("fair_order", int'(rsp_valid), 1 << (n_str % 4));
                chk("fair_dout", int'(rsp_dout), fp[n_str % 4]);
                n_str++;
            end
            if (c >= 1 && c < 8) chk("b2b_inflight", int'(inflight), 2);
        end
        chk("fair_count", n_str, 8);

        // Stall: en is held low for 3 cycles while op0 is being strobed and op1 is in flight.
        do_reset();
        load_fair_ops();
        req_valid = 4'hF;
        step();
        step();
        chk("stall_pre_rsp", int'(rsp_valid), 1);
        chk("stall_pre_dout", int'(rsp_dout), -1000);
        chk("stall_pre_inflight", int'(inflight), 2);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_ready", int'(req_ready), 0);
            step();
            chk("stall_rsp", int'(rsp_valid), 1);
            chk("stall_dout", int'(rsp_dout), -1000);
            chk("stall_inflight", int'(inflight), 2);
        end
        en = 1'b1;
        #1;
        chk("stall_resume_grant", int'(req_ready), 4'b0100);
        step();
        req_valid = '0;
        chk("stall_op1_rsp", int'(rsp_valid), 2);
        chk("stall_op1_dout", int'(rsp_dout), 4000);
        chk("stall_op1_inflight", int'(inflight), 2);
        step();
        chk("stall_op2_rsp", int'(rsp_valid), 4);
        chk("stall_op2_dout", int'(rsp_dout), -9000);
        chk("stall_op2_inflight", int'(inflight), 1);
        step();
        chk("stall_drain_rsp", int'(rsp_valid), 0);
        chk("stall_drain_inflight", int'(inflight), 0);

        // Reset mid-operation: ap_rst_n pulses low between edges while 2 operations are in flight.
        do_reset();
        load_fair_ops();
        req_valid = 4'hF;
        step();
        step();
        chk("mrst_pre_rsp", int'(rsp_valid), 1);
        chk("mrst_pre_inflight", int'(inflight), 2);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("mrst_rsp", int'(rsp_valid), 0);
        chk("mrst_dout", int'(rsp_dout), 0);
        chk("mrst_inflight", int'(inflight), 0);
        chk("mrst_ready", int'(req_ready), 0);
        #1;
        ap_rst_n = 1'b1;
        #1;
        chk("mrst_ptr_restart", int'(req_ready), 1);
        step();
        chk("mrst_no_stale", int'(rsp_valid), 0);
        chk("mrst_inflight_acc", int'(inflight), 1);
        step();
        req_valid = '0;
        chk("mrst_new_rsp", int'(rsp_valid), 1);
        chk("mrst_new_dout", int'(rsp_dout), -1000);
        chk("mrst_new_inflight", int'(inflight), 2);
        step();
        step();
        step();

        // Continuous traffic from a single requester keeps inflight at NUM_STAGE.
        req_valid = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("single_ready", int'(req_ready), 2);
            step();
            if (c >= 1) chk("single_inflight", int'(inflight), 2);
        end
        req_valid = '0;
        step();
        step();
        chk("single_drain_inflight", int'(inflight), 0);
        chk("single_drain_rsp", int'(rsp_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
